piso_shift_controller: RTL and testbench

Sequencer for the 8-bit parallel-in/serial-out shift register (PL, CP1, CP2, DS, Q, QB).
- Drives the register's parallel-load and clock-inhibit pins to capture one parallel word, then shifts it out serially.
- Samples serial output Q and reassembles the word.
- Presents the word on a valid/ready handshake.
- Sits between the register and any consumer that wants parallel snapshots of the P0..P7 inputs.

---
 rtl/piso_shift_controller_pkg.sv | 18 +
 rtl/piso_bit_counter.sv | 24 ++
 rtl/piso_shift_controller.sv | 110 +++++++++++
 tb/tb_piso_shift_controller.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/piso_shift_controller_pkg.sv
// Shared types and helpers for the PISO shift-register sequencer.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned PISO_WIDTH_DEF = 8;

  // True when data bits plus parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [63:0] data, input logic par_bit);
    return (^data) ^ par_bit;
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit counter with synchronous clear, enable and terminal count at a programmable limit.
module piso_bit_counter #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == limit);

endmodule

// File: rtl/piso_shift_controller.sv
// Sequencer that parallel-loads a PISO register, shifts it out and reassembles the word.
// Optional odd-parity check on an extra serial bit is enabled with `define PISO_PARITY_EN.
module piso_shift_controller
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = PISO_WIDTH_DEF,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             cp,
  input  logic             mr,
  input  logic             start,
  output logic             busy,
  output logic             pl_n,
  output logic             cp_inh,
  input  logic             q_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  input  logic             ready
`ifdef PISO_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  if (WIDTH < 2) begin : g_width_check
    $error("piso_shift_controller: WIDTH must be at least 2");
  end

`ifdef PISO_PARITY_EN
  localparam int unsigned LAST = WIDTH;
  localparam int unsigned CW   = $clog2(WIDTH + 1);
  localparam int unsigned SR_W = WIDTH;
`else
  localparam int unsigned LAST = WIDTH - 1;
  localparam int unsigned CW   = CNT_W;
  localparam int unsigned SR_W = WIDTH - 1;
`endif

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic            tc;
  logic [SR_W-1:0] shreg;

  piso_bit_counter #(
    .CNT_W (CW)
  ) u_bit_counter (
    .clk   (cp),
    .rst   (mr),
    .clr   (state == LOAD),
    .en    (state == SHIFT),
    .limit (CW'(LAST)),
    .cnt   (cnt),
    .tc    (tc)
  );

  always_ff @(posedge cp) begin
    if (mr) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start) state_next = LOAD;
      LOAD:  state_next = SHIFT;
      SHIFT: if (tc) state_next = DONE;
      DONE:  if (ready) state_next = start ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy   = (state != IDLE);
  assign pl_n   = (state != LOAD);
  assign valid  = (state == DONE);
  // The register stops shifting on the final SHIFT cycle so Q keeps its last bit.
  assign cp_inh = !((state == SHIFT) && (cnt < CW'(LAST)));

  // The final data bit is taken straight from q_in, so shreg only holds the earlier bits
  // unless a parity bit follows the data.
  always_ff @(posedge cp) begin
    if (mr) begin
      shreg    <= '0;
      data_out <= '0;
`ifdef PISO_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      if (state == SHIFT) begin
        shreg <= SR_W'({shreg, q_in});
        if (tc) begin
`ifdef PISO_PARITY_EN
          data_out   <= shreg;
          parity_err <= !odd_parity_ok(64'(shreg), q_in);
`else
          data_out <= {shreg, q_in};
`endif
        end
      end
`ifdef PISO_PARITY_EN
      if (state == DONE && ready) begin
        parity_err <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_piso_shift_controller.sv
// Directed bench for piso_shift_controller with a behavioural 8-bit PISO register model.
module tb_piso_shift_controller;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int EXP_LAT = 10;
  localparam int EXP_INH = 8;
`else
  localparam int EXP_LAT = 9;
  localparam int EXP_INH = 7;
`endif

  logic         cp = 1'b0;
  logic         mr = 1'b1;
  logic         start = 1'b0;
  logic         ready = 1'b0;
  logic         busy, pl_n, cp_inh, q_in, valid;
  logic [W-1:0] data_out;
`ifdef PISO_PARITY_EN
  logic         parity_err;
`endif

  logic [7:0] p  = 8'h00;
  logic [7:0] sr = 8'h00;
  logic       ds = 1'b1;

  int tests_run    = 0;
  int tests_failed = 0;

  piso_shift_controller #(
    .WIDTH (W)
  ) dut (
    .cp       (cp),
    .mr       (mr),
    .start    (start),
    .busy     (busy),
    .pl_n     (pl_n),
    .cp_inh   (cp_inh),
    .q_in     (q_in),
    .data_out (data_out),
    .valid    (valid),
    .ready    (ready)
`ifdef PISO_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 cp = ~cp;

  // External register: PL low shows P7 on Q and loads, CP2 low lets CP1 shift DS in.
  always @(posedge cp) begin
    if (pl_n === 1'b0) sr <= p;
    else if (cp_inh === 1'b0) sr <= {sr[6:0], ds};
  end
  assign q_in = (pl_n === 1'b0) ? p[7] : sr[7];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge cp);
    #1;
  endtask

  // Called just after the edge that sampled start; counts edges until valid.
  task automatic wait_valid(output int lat, output int pl_low, output int inh_low, output int idle);
    lat = -1; pl_low = 0; inh_low = 0; idle = 0;
    for (int k = 0; k < 40; k++) begin
      if (!pl_n) pl_low++;
      if (!cp_inh) inh_low++;
      if (!busy) idle++;
      if (valid) begin
        lat = k;
        return;
      end
      tick();
    end
  endtask

  task automatic capture(input logic [7:0] word, input logic pbit, output int lat);
    int pl_low, inh_low, idle;
    p = word;
    ds = pbit;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(lat, pl_low, inh_low, idle);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, lat2, pl_low, inh_low, idle;

    // 1: reset
    mr = 1'b1;
    tick();
    tick();
    mr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_pl_n", pl_n, 1'b1);
      check("rst_cp_inh", cp_inh, 1'b1);
      check("rst_valid", valid, 1'b0);
      check("rst_data", data_out, 8'h00);
      check("rst_busy", busy, 1'b0);
    end

    // 2: single capture of 0x30
    p = 8'h30; ds = 1'b1; ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(lat, pl_low, inh_low, idle);
    check("s2_latency", lat, EXP_LAT);
    check("s2_pl_low", pl_low, 1);
    check("s2_inh_low", inh_low, EXP_INH);
    check("s2_data", data_out, 8'h30);
    tick();
    check("s2_idle_busy", busy, 1'b0);
    check("s2_idle_valid", valid, 1'b0);
    check("s2_data_kept", data_out, 8'h30);

    // 3: consumer stalls for 5 cycles
    ready = 1'b0;
    capture(8'hA5, 1'b1, lat);
    check("s3_latency", lat, EXP_LAT);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("s3_hold_valid", valid, 1'b1);
      check("s3_hold_data", data_out, 8'hA5);
    end
    ready = 1'b1;
    tick();
    check("s3_drop_valid", valid, 1'b0);
    check("s3_drop_busy", busy, 1'b0);

    // 4: back-to-back captures with start held
    p = 8'h3C; ds = 1'b1;
    start = 1'b1;
    tick();
    wait_valid(lat, pl_low, inh_low, idle);
    check("s4_lat1", lat, EXP_LAT);
    check("s4_data1", data_out, 8'h3C);
    p = 8'hC3;
    tick();
    wait_valid(lat2, pl_low, inh_low, idle);
    check("s4_spacing", lat2 + 1, EXP_LAT + 1);
    check("s4_no_idle", idle, 0);
    check("s4_pl_low", pl_low, 1);
    check("s4_data2", data_out, 8'hC3);
    start = 1'b0;
    tick();
    check("s4_end_busy", busy, 1'b0);

    // 5: reset in the middle of SHIFT
    p = 8'h96;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("s5_mid_shift_inh", cp_inh, 1'b0);
    check("s5_mid_shift_busy", busy, 1'b1);
    mr = 1'b1;
    tick();
    mr = 1'b0;
    check("s5_rst_busy", busy, 1'b0);
    check("s5_rst_inh", cp_inh, 1'b1);
    check("s5_rst_pl_n", pl_n, 1'b1);
    check("s5_rst_valid", valid, 1'b0);
    check("s5_rst_data", data_out, 8'h00);
    capture(8'h5A, 1'b1, lat);
    check("s5_after_lat", lat, EXP_LAT);
    check("s5_after_data", data_out, 8'h5A);
    tick();
    check("s5_after_idle", busy, 1'b0);

`ifdef PISO_PARITY_EN
    // 6: odd parity on the bit after the data
    capture(8'h30, 1'b1, lat);
    check("s6_lat", lat, 10);
    check("s6_data_ok", data_out, 8'h30);
    check("s6_perr_ok", parity_err, 1'b0);
    tick();
    capture(8'h30, 1'b0, lat);
    check("s6_data_bad", data_out, 8'h30);
    check("s6_perr_bad", parity_err, 1'b1);
    tick();
    check("s6_perr_clr", parity_err, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
